// File: rtl/neonfox_mem_pkg.sv
// Shared types and constants for the NeonFox memory-port arbiter.
package neonfox_mem_pkg;

  // Identity of the port currently owning the SDRAM burst.
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_P1   = 2'd1,
    PORT_P2   = 2'd2,
    PORT_P3   = 2'd3
  } port_e;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Words per SDRAM burst.
  localparam int BURST_LEN = 4;

endpackage

// File: rtl/sdram_port_prio.sv
// Combinational priority picker: starved ports first (p2 before p1),
// otherwise fixed p3 > p2 > p1. Returns a one-hot grant {p3, p2, p1}.
module sdram_port_prio (
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic       p3_req,
  input  logic       p1_starved,
  input  logic       p2_starved,
  output logic [2:0] grant
);

  // Priority chain; at most one grant bit set.
  always_comb begin
    grant = 3'b000;
    if (p2_req && p2_starved) begin
      grant = 3'b010;
    end else if (p1_req && p1_starved) begin
      grant = 3'b001;
    end else if (p3_req) begin
      grant = 3'b100;
    end else if (p2_req) begin
      grant = 3'b010;
    end else if (p1_req) begin
      grant = 3'b001;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port 4-word burst arbiter in front of the single-port SDRAM controller.
// Grants one port per burst, maps its address into SDRAM word space, routes the
// controller's per-word handshake to the winner and guards p1/p2 from starvation.
module sdram_port_arbiter
  import neonfox_mem_pkg::*;
#(
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] P3_BASE      = ADDR_W'(24'hFE0000),
  parameter int                STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p1_req,
  input  logic [31:0]       p1_address,
  output logic              p1_ready,
  output logic [1:0]        p1_offset,
  input  logic              p2_req,
  input  logic              p2_wren,
  input  logic [31:0]       p2_address,
  input  logic [15:0]       p2_to_mem,
  output logic              p2_ready,
  output logic [1:0]        p2_offset,
  input  logic              p3_req,
  input  logic              p3_wren,
  input  logic [16:0]       p3_address,
  input  logic [15:0]       p3_to_mem,
  output logic              p3_ready,
  output logic [1:0]        p3_offset,
  output logic [15:0]       from_mem,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_to_mem,
  input  logic              mem_ready,
  input  logic [1:0]        mem_offset,
  input  logic [15:0]       mem_data,
  output logic              proto_err
);

  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [1:0]        beat_q, beat_d;
  logic [3:0]        p1_cnt_q, p1_cnt_d;
  logic [3:0]        p2_cnt_q, p2_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic [2:0]        pick;
  logic [ADDR_W-1:0] p1_map, p2_map, p3_map, p3_sum;
  logic [16:0]       p3_word;
  logic              unused_addr_bits;

  // Low two address bits are burst-internal and high bits beyond the SDRAM
  // word space have no meaning; fold them into a sink so they stay visible.
  assign unused_addr_bits = ^{p1_address, p2_address, p3_address[1:0]};

  // Burst base addresses, always aligned to a 4-word boundary.
  assign p1_map  = {p1_address[ADDR_W-1:2], 2'b00};
  assign p2_map  = {p2_address[ADDR_W-1:2], 2'b00};
  assign p3_word = {p3_address[16:2], 2'b00};
  assign p3_sum  = P3_BASE + ADDR_W'(p3_word);
  assign p3_map  = {p3_sum[ADDR_W-1:2], 2'b00};

  sdram_port_prio u_prio (
    .p1_req     (p1_req),
    .p2_req     (p2_req),
    .p3_req     (p3_req),
    .p1_starved (p1_cnt_q == LIMIT),
    .p2_starved (p2_cnt_q == LIMIT),
    .grant      (pick)
  );

  // Saturating increment for the lost-arbitration counters.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? cnt : cnt + 4'd1;
  endfunction

  // Next-state: grant decision in IDLE, beat counting in BUSY, one dead cycle in DONE.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wren_d      = wren_q;
    beat_d      = beat_q;
    p1_cnt_d    = p1_cnt_q;
    p2_cnt_d    = p2_cnt_q;
    // A beat outside a granted burst means the controller is out of step.
    proto_err_d = proto_err_q | (mem_ready & (state_q != BUSY));

    case (state_q)
      IDLE: begin
        if (|pick) begin
          state_d = BUSY;
          beat_d  = 2'd0;
          if (pick[2]) begin
            grant_d = PORT_P3;
            addr_d  = p3_map;
            wren_d  = p3_wren;
          end else if (pick[1]) begin
            grant_d = PORT_P2;
            addr_d  = p2_map;
            wren_d  = p2_wren;
          end else begin
            grant_d = PORT_P1;
            addr_d  = p1_map;
            wren_d  = 1'b0;   // program cache is read-only
          end
          p1_cnt_d = pick[0] ? 4'd0 : (p1_req ? sat_inc(p1_cnt_q) : p1_cnt_q);
          p2_cnt_d = pick[1] ? 4'd0 : (p2_req ? sat_inc(p2_cnt_q) : p2_cnt_q);
        end
      end
      BUSY: begin
        if (mem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Give the finished master a cycle to drop req before re-arbitrating.
        state_d = IDLE;
        grant_d = PORT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = PORT_NONE;
      end
    endcase
  end

  // State and context registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= PORT_NONE;
      addr_q      <= '0;
      wren_q      <= 1'b0;
      beat_q      <= 2'd0;
      p1_cnt_q    <= 4'd0;
      p2_cnt_q    <= 4'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wren_q      <= wren_d;
      beat_q      <= beat_d;
      p1_cnt_q    <= p1_cnt_d;
      p2_cnt_q    <= p2_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Output routing: everything is quiet unless a burst is in progress.
  always_comb begin
    mem_req     = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_to_mem  = 16'd0;
    from_mem    = 16'd0;
    p1_ready    = 1'b0;
    p1_offset   = 2'd0;
    p2_ready    = 1'b0;
    p2_offset   = 2'd0;
    p3_ready    = 1'b0;
    p3_offset   = 2'd0;
    proto_err   = proto_err_q;
    if (state_q == BUSY) begin
      mem_req     = 1'b1;
      mem_wren    = wren_q;
      mem_address = addr_q;
      from_mem    = mem_data;
      case (grant_q)
        PORT_P1: begin
          p1_ready  = mem_ready;
          p1_offset = mem_offset;
        end
        PORT_P2: begin
          p2_ready   = mem_ready;
          p2_offset  = mem_offset;
          mem_to_mem = p2_to_mem;
        end
        PORT_P3: begin
          p3_ready   = mem_ready;
          p3_offset  = mem_offset;
          mem_to_mem = p3_to_mem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a scoreboard of expected bursts is filled
// as requests are raised and drained by a small SDRAM controller model.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p1_req, p2_req, p2_wren, p3_req, p3_wren;
  logic [31:0] p1_address, p2_address;
  logic [16:0] p3_address;
  logic [15:0] p2_to_mem, p3_to_mem, from_mem, mem_to_mem, mem_data;
  logic        p1_ready, p2_ready, p3_ready;
  logic [1:0]  p1_offset, p2_offset, p3_offset, mem_offset;
  logic        mem_req, mem_wren, mem_ready, proto_err;
  logic [23:0] mem_address;

  int checks   = 0;
  int failures = 0;
  int gap;

  typedef struct {
    int          port;
    logic [23:0] addr;
    logic        wren;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .p1_req(p1_req), .p1_address(p1_address), .p1_ready(p1_ready), .p1_offset(p1_offset),
    .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
    .p2_ready(p2_ready), .p2_offset(p2_offset),
    .p3_req(p3_req), .p3_wren(p3_wren), .p3_address(p3_address), .p3_to_mem(p3_to_mem),
    .p3_ready(p3_ready), .p3_offset(p3_offset),
    .from_mem(from_mem), .mem_req(mem_req), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_to_mem(mem_to_mem), .mem_ready(mem_ready), .mem_offset(mem_offset),
    .mem_data(mem_data), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic [23:0] addr, input logic wren);
    exp_t e;
    e.port = port;
    e.addr = addr;
    e.wren = wren;
    sb.push_back(e);
  endtask

  // Controller model: wait for the next burst, check it against the scoreboard,
  // then return nbeats words on consecutive cycles. gap = mem_req-low cycles seen.
  task automatic run_burst(input int nbeats, output int gap_o);
    exp_t        e;
    logic [15:0] rd, exp_tm;
    logic [2:0]  er;
    logic [5:0]  eo;
    gap_o = 0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    #1;
    while (mem_req !== 1'b1 && gap_o < 20) begin
      @(negedge clk);
      #1;
      gap_o++;
    end
    if (mem_req !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL mem_req_timeout observed=%b expected=1", mem_req);
      return;
    end
    $display("burst port=p%0d addr=%h wren=%b gap=%0d", e.port, mem_address, mem_wren, gap_o);
    chk("mem_address", 32'(mem_address), 32'(e.addr));
    chk("mem_wren", 32'(mem_wren), 32'(e.wren));
    for (int b = 0; b < nbeats; b++) begin
      rd         = 16'hA000 + 16'(e.port * 256) + 16'(b);
      mem_ready  = 1'b1;
      mem_offset = 2'(b);
      mem_data   = rd;
      p2_to_mem  = 16'h2200 + 16'(b);
      p3_to_mem  = 16'h3300 + 16'(b);
      exp_tm     = (e.port == 3) ? p3_to_mem : (e.port == 2) ? p2_to_mem : 16'h0000;
      er         = 3'(1 << (e.port - 1));
      eo         = 6'(b << (2 * (e.port - 1)));
      #1;
      chk($sformatf("beat%0d_ready", b), 32'({p3_ready, p2_ready, p1_ready}), 32'(er));
      chk($sformatf("beat%0d_offset", b), 32'({p3_offset, p2_offset, p1_offset}), 32'(eo));
      chk($sformatf("beat%0d_from_mem", b), 32'(from_mem), 32'(rd));
      chk($sformatf("beat%0d_mem_to_mem", b), 32'(mem_to_mem), 32'(exp_tm));
      @(negedge clk);
    end
    if (nbeats == 4) begin
      mem_ready = 1'b0;
      #1;
      chk("done_mem_req", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    p1_req = 0; p2_req = 0; p3_req = 0; p2_wren = 0; p3_wren = 0;
    p1_address = '0; p2_address = '0; p3_address = '0;
    p2_to_mem = '0; p3_to_mem = '0;
    mem_ready = 0; mem_offset = '0; mem_data = 16'hBEEF;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_from_mem", 32'(from_mem), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_p1_cnt", 32'(dut.p1_cnt_q), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single p1 read
    @(negedge clk);
    p1_req = 1; p1_address = 32'h0000_1235;
    push(1, 24'h001234, 1'b0);
    run_burst(4, gap);
    chk("p1_latency", 32'(gap), 32'd1);
    p1_req = 0;

    // p3 write mapping
    p3_req = 1; p3_wren = 1; p3_address = 17'h00010;
    push(3, 24'hFE0010, 1'b1);
    run_burst(4, gap);
    p3_req = 0; p3_wren = 0;

    // Contention: all three at once
    p1_address = 32'h00AB_CDEF; p2_address = 32'h0012_3458; p2_wren = 1;
    p3_address = 17'h1_0007;    p3_wren = 0;
    p1_req = 1; p2_req = 1; p3_req = 1;
    push(3, 24'hFF0004, 1'b0);
    push(2, 24'h123458, 1'b1);
    push(1, 24'hABCDEC, 1'b0);
    run_burst(4, gap);
    chk("cont_gap_p3", 32'(gap), 32'd2);
    p3_req = 0;
    run_burst(4, gap);
    chk("cont_gap_p2", 32'(gap), 32'd2);
    p2_req = 0; p2_wren = 0;
    run_burst(4, gap);
    chk("cont_gap_p1", 32'(gap), 32'd2);
    p1_req = 0;

    // Starvation: p1 pending, p3 continuous, p2 joins later
    p1_address = 32'h0000_0100; p2_address = 32'h0000_0200; p3_address = 17'h00020;
    p1_req = 1; p3_req = 1;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) p2_req = 1;
      if (k == 9) begin
        chk("starve_p1_cnt_full", 32'(dut.p1_cnt_q), 32'd8);
        push(1, 24'h000100, 1'b0);
      end else begin
        push(3, 24'hFE0020, 1'b0);
      end
      run_burst(4, gap);
    end
    chk("starve_p1_cnt_clear", 32'(dut.p1_cnt_q), 32'd0);
    chk("starve_p2_cnt", 32'(dut.p2_cnt_q), 32'd6);
    p1_req = 0; p2_req = 0; p3_req = 0;

    // Spurious ready in IDLE
    repeat (2) @(negedge clk);
    mem_ready = 1; mem_offset = 2'd3; mem_data = 16'h5A5A;
    #1;
    chk("spur_ready", 32'({p3_ready, p2_ready, p1_ready}), 32'd0);
    chk("spur_from_mem", 32'(from_mem), 32'd0);
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("spur_proto_err", 32'(proto_err), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("spur_proto_err_sticky", 32'(proto_err), 32'd1);
    chk("spur_mem_req", 32'(mem_req), 32'd0);

    // Reset mid-burst
    @(negedge clk);
    p2_req = 1; p2_wren = 0; p2_address = 32'h00FF_0ABE;
    push(2, 24'hFF0ABC, 1'b0);
    run_burst(2, gap);
    mem_offset = 2'd2;
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", 32'(mem_address), 32'd0);
    chk("midrst_ready", 32'({p3_ready, p2_ready, p1_ready}), 32'd0);
    chk("midrst_from_mem", 32'(from_mem), 32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    chk("midrst_p2_cnt", 32'(dut.p2_cnt_q), 32'd0);
    mem_ready = 0;
    @(negedge clk);
    reset = 1'b1;
    push(2, 24'hFF0ABC, 1'b0);
    run_burst(4, gap);
    chk("postrst_latency", 32'(gap), 32'd1);
    p2_req = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("postrst_proto_err", 32'(proto_err), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
